xcvr_dir_ctl: RTL
=================

Name: xcvr_dir_ctl

Overview:
- Direction/enable sequencer for the pair of Am2949 octal bidirectional transceivers (upper and lower byte lanes) between the 68010 local data bus (A side) and the off-board bus (B side).
- Converts CPU strobes plus address decode into transceiver T_n/R_n controls, a dead turnaround window, dtack_n back to the CPU, and an optional bus-timeout berr_n.
- Sits directly upstream of the transceivers and guarantees T_n and R_n of a lane are never both low.

Parameters:
- TURN_CYC, 1, dead cycles with all transceivers disabled before driving (0 = skip TURN state)
- TIMEOUT, 255, cycles in DRIVE without bus ack before bus error (timeout feature only)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- as_n  input  1  CPU address strobe, already synchronized to clk
- uds_n  input  1  upper data strobe, synchronized
- lds_n  input  1  lower data strobe, synchronized
- rw  input  1  1 = read (B→A), 0 = write (A→B)
- sel  input  1  address decode: cycle targets off-board bus
- bus_ack_n  input  1  off-board transfer acknowledge, synchronized
- t_hi_n  output  1  upper transceiver T_n (drive A→B)
- r_hi_n  output  1  upper transceiver R_n (drive B→A)
- t_lo_n  output  1  lower transceiver T_n
- r_lo_n  output  1  lower transceiver R_n
- dtack_n  output  1  acknowledge to CPU
- berr_n  output  1  bus error to CPU
- busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on port reset.
- All outputs are registered. Reset state: IDLE; all t_*_n/r_*_n = 1; dtack_n = 1; berr_n = 1; busy = 0; counters = 0.
- States: IDLE, TURN, DRIVE, ACK, ERR.
- IDLE:
  - Start condition: as_n=0, sel=1, and (uds_n=0 or lds_n=0).
  - On start, latch rw, hi_en=~uds_n and lo_en=~lds_n, then go to TURN (or to DRIVE if TURN_CYC=0).
  - as_n=0 with both data strobes high does not start a cycle.
- TURN: all enables high. Stays TURN_CYC cycles, then goes to DRIVE.
- Latency: enables go low at the edge start+1+TURN_CYC.
- DRIVE:
  - Latched write: t_*_n=0 on enabled lanes. Latched read: r_*_n=0 on enabled lanes.
  - The opposite control stays 1, and disabled lanes stay fully off.
  - bus_ack_n=0 → ACK.
- ACK: dtack_n=0, enables held so read data stays valid. When as_n=1, the next edge sets all enables=1 and dtack_n=1, state → IDLE.
- Strobe changes after the latch are ignored until IDLE.
- Abort: as_n=1 in TURN or DRIVE → IDLE next edge, all enables off, no dtack.
- Back-to-back cycles always pass through TURN, even with the same direction.
- Reset mid-cycle forces the reset state at the next edge, regardless of state.
- Invariant: each lane never has T_n=0 and R_n=0 together; at most one direction is active.

Optional Feature:
- Macro: XCVR_DIR_CTL_TIMEOUT_EN.
- With the macro:
  - A counter of width $clog2(TIMEOUT+1) clears on DRIVE entry and increments each DRIVE cycle.
  - When it reaches TIMEOUT with bus_ack_n still 1 → ERR: enables off, berr_n=0, dtack_n=1.
  - ERR holds until as_n=1, then goes to IDLE with berr_n=1.
  - If ack and timeout occur in the same cycle, ack wins.
- Without the macro: no counter and no ERR state. berr_n is tied 1 and DRIVE waits indefinitely.

Decomposition:
- Package xcvr_pkg holds:
  - the state enum;
  - localparams for the lane index (HI=1, LO=0);
  - the encoding constants DIR_WRITE=0 and DIR_READ=1.
- One natural sub-module: bus_timeout_ctr (clear, enable, terminal-count output), instantiated only under the macro.

Test Plan:
- Reset: assert reset for 2 cycles mid-DRIVE → all enables=1, dtack_n=1, berr_n=1, busy=0 on the next edge.
- Word write, TURN_CYC=1:
  - Stimulus: as_n=0, uds_n=lds_n=0, rw=0, sel=1 at cycle 0.
  - Enables: t_hi_n=t_lo_n=0 at cycle 2; r_*_n stay 1.
  - Ack: bus_ack_n=0 at cycle 5 → dtack_n=0 at cycle 6.
  - Release: as_n=1 at cycle 8 → all enables=1 and dtack_n=1 at cycle 9.
- Lower-byte read: lds_n=0, uds_n=1, rw=1 → only r_lo_n=0. t_hi_n, r_hi_n, t_lo_n stay 1 for the whole cycle.
- Abort: as_n rises in DRIVE before ack → IDLE next edge, dtack_n never asserted.
- Timeout, macro defined, TIMEOUT=4: no ack → berr_n=0 four cycles after DRIVE entry, enables off. Release as_n → berr_n=1.
- Contention check: random strobe/rw/ack/as_n sequences for 10k cycles → the assertion that no lane has T_n=0 and R_n=0 together never fires.

Source files
------------

// File: rtl/xcvr_dir_ctl_pkg.sv
// Shared types and constants for the Am2949 transceiver direction sequencer.
// The ERR state exists only when XCVR_DIR_CTL_TIMEOUT_EN is defined.
package xcvr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TURN  = 3'd1,
    ST_DRIVE = 3'd2,
`ifdef XCVR_DIR_CTL_TIMEOUT_EN
    ST_ACK   = 3'd3,
    ST_ERR   = 3'd4
`else
    ST_ACK   = 3'd3
`endif
  } state_t;

  localparam int HI = 1;
  localparam int LO = 0;

  localparam logic DIR_WRITE = 1'b0;
  localparam logic DIR_READ  = 1'b1;

  // Returns {T_n, R_n} for one lane; both can never be low together.
  function automatic logic [1:0] lane_ctl(input logic drive, input logic en, input logic dir);
    logic on;
    on = drive & en;
    return {~(on & (dir == DIR_WRITE)), ~(on & (dir == DIR_READ))};
  endfunction

endpackage

// File: rtl/xcvr_dir_ctl_if.sv
// CPU strobe / off-board ack inputs and transceiver control outputs of the
// direction sequencer. master = CPU/bus side, slave = the sequencer.
interface xcvr_dir_ctl_if;
  logic as_n;
  logic uds_n;
  logic lds_n;
  logic rw;
  logic sel;
  logic bus_ack_n;
  logic t_hi_n;
  logic r_hi_n;
  logic t_lo_n;
  logic r_lo_n;
  logic dtack_n;
  logic berr_n;
  logic busy;

  modport master (
    output as_n, uds_n, lds_n, rw, sel, bus_ack_n,
    input  t_hi_n, r_hi_n, t_lo_n, r_lo_n, dtack_n, berr_n, busy
  );

  modport slave (
    input  as_n, uds_n, lds_n, rw, sel, bus_ack_n,
    output t_hi_n, r_hi_n, t_lo_n, r_lo_n, dtack_n, berr_n, busy
  );
endinterface

// File: rtl/xcvr_dir_ctl_bus_timeout_ctr.sv
// DRIVE-phase watchdog: counts enabled cycles and flags the cycle whose
// increment reaches TIMEOUT. Used only with XCVR_DIR_CTL_TIMEOUT_EN.
module bus_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Flag one cycle early so the FSM leaves DRIVE exactly TIMEOUT cycles after entry.
  assign tc = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/xcvr_dir_ctl.sv
// Direction/enable sequencer for the upper/lower Am2949 transceiver pair.
// Optional bus timeout (berr_n) enabled by defining XCVR_DIR_CTL_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no cycle; all transceivers off
// TURN  | dead turnaround, all transceivers off, TURN_CYC cycles
// DRIVE | latched direction driven on enabled lanes, waiting bus ack
// ACK   | dtack_n low, lanes held until as_n rises
// ERR   | bus timeout: lanes off, berr_n low until as_n rises
module xcvr_dir_ctl
  import xcvr_pkg::*;
#(
  parameter int TURN_CYC = 1,
  parameter int TIMEOUT  = 255
) (
  input logic           clk,
  input logic           reset,
  xcvr_dir_ctl_if.slave bus
);

  localparam int TURN_W    = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam int TURN_LOAD = (TURN_CYC > 0) ? TURN_CYC - 1 : 0;

  state_t            state, state_nxt;
  logic              dir, dir_nxt;
  logic [1:0]        lane_en, lane_en_nxt;
  logic [TURN_W-1:0] turn_cnt, turn_nxt;

  logic [1:0] t_n_q, r_n_q, t_n_nxt, r_n_nxt;
  logic       dtack_q, dtack_nxt;
  logic       berr_q, berr_nxt;
  logic       busy_q, busy_nxt;
  logic       start;
  logic       drive_nxt;

  assign start = ~bus.as_n & bus.sel & (~bus.uds_n | ~bus.lds_n);

`ifdef XCVR_DIR_CTL_TIMEOUT_EN
  logic tmo_tc;

  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clear (state != ST_DRIVE),
    .en    (state == ST_DRIVE),
    .tc    (tmo_tc)
  );
`endif

  always_comb begin
    state_nxt   = state;
    dir_nxt     = dir;
    lane_en_nxt = lane_en;
    turn_nxt    = turn_cnt;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          dir_nxt         = bus.rw;
          lane_en_nxt[HI] = ~bus.uds_n;
          lane_en_nxt[LO] = ~bus.lds_n;
          turn_nxt        = TURN_W'(TURN_LOAD);
          state_nxt       = (TURN_CYC == 0) ? ST_DRIVE : ST_TURN;
        end
      end
      ST_TURN: begin
        if (bus.as_n) begin
          state_nxt = ST_IDLE;
        end else if (turn_cnt == '0) begin
          state_nxt = ST_DRIVE;
        end else begin
          turn_nxt = turn_cnt - TURN_W'(1);
        end
      end
      ST_DRIVE: begin
        // Abort beats ack; ack beats timeout.
        if (bus.as_n) begin
          state_nxt = ST_IDLE;
        end else if (!bus.bus_ack_n) begin
          state_nxt = ST_ACK;
        end
`ifdef XCVR_DIR_CTL_TIMEOUT_EN
        else if (tmo_tc) begin
          state_nxt = ST_ERR;
        end
`endif
      end
      ST_ACK: begin
        if (bus.as_n) state_nxt = ST_IDLE;
      end
`ifdef XCVR_DIR_CTL_TIMEOUT_EN
      ST_ERR: begin
        if (bus.as_n) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    drive_nxt = (state_nxt == ST_DRIVE) || (state_nxt == ST_ACK);
    {t_n_nxt[HI], r_n_nxt[HI]} = lane_ctl(drive_nxt, lane_en_nxt[HI], dir_nxt);
    {t_n_nxt[LO], r_n_nxt[LO]} = lane_ctl(drive_nxt, lane_en_nxt[LO], dir_nxt);
    dtack_nxt = ~(state_nxt == ST_ACK);
`ifdef XCVR_DIR_CTL_TIMEOUT_EN
    berr_nxt  = ~(state_nxt == ST_ERR);
`else
    berr_nxt  = 1'b1;
`endif
    busy_nxt  = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      dir      <= DIR_WRITE;
      lane_en  <= '0;
      turn_cnt <= '0;
      t_n_q    <= '1;
      r_n_q    <= '1;
      dtack_q  <= 1'b1;
      berr_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      lane_en  <= lane_en_nxt;
      turn_cnt <= turn_nxt;
      t_n_q    <= t_n_nxt;
      r_n_q    <= r_n_nxt;
      dtack_q  <= dtack_nxt;
      berr_q   <= berr_nxt;
      busy_q   <= busy_nxt;
    end
  end

  assign bus.t_hi_n  = t_n_q[HI];
  assign bus.r_hi_n  = r_n_q[HI];
  assign bus.t_lo_n  = t_n_q[LO];
  assign bus.r_lo_n  = r_n_q[LO];
  assign bus.dtack_n = dtack_q;
  assign bus.berr_n  = berr_q;
  assign bus.busy    = busy_q;

endmodule
